// File: rtl/abc_pkg.sv
// ---------------------------------------------------------------------------
// abc_pkg
//   Shared definitions for the abc_responder block: FSM state encoding and
//   default parameter values used by the top level and its bus interface.
// ---------------------------------------------------------------------------
package abc_pkg;

    // Cycles after reset release during which every request is refused.
    localparam int HOLDOFF_CYCLES_DEFAULT = 20;

    // Width of the statistics counters.
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_HOLDOFF = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2
    } state_e;

endpackage : abc_pkg

// File: rtl/abc_responder_if.sv
// ---------------------------------------------------------------------------
// abc_responder_if
//   Request/response bus of the abc_responder.
//   master : drives a, enable, inject_err; observes responses and statistics
//   slave  : the responder side
//   Signals:
//     a           request, one transaction per sampled-high cycle
//     enable      responder enable
//     inject_err  suppresses c of the transaction accepted in the same cycle
//     b, c, d     first phase, second phase, done pulse
//     busy        any accepted transaction still in flight
//     ready       responder is in RUN
//     txn_count   transactions completed with c
//     err_count   transactions completed with c suppressed
//     drop_count  refused requests
// ---------------------------------------------------------------------------
interface abc_responder_if
    import abc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) ();

    logic             a;
    logic             enable;
    logic             inject_err;
    logic             b;
    logic             c;
    logic             d;
    logic             busy;
    logic             ready;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] drop_count;

    modport master (
        output a, enable, inject_err,
        input  b, c, d, busy, ready, txn_count, err_count, drop_count
    );

    modport slave (
        input  a, enable, inject_err,
        output b, c, d, busy, ready, txn_count, err_count, drop_count
    );

endinterface : abc_responder_if

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up counter that stops at its all-ones value instead of wrapping.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset, clears the count
//     inc    increment request for this cycle
//     q      current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its sources, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign q = cnt_q;

endmodule : sat_counter

// File: rtl/abc_responder.sv
// ---------------------------------------------------------------------------
// abc_responder
//   Accepts single-cycle requests and answers each with a fixed two-phase
//   response: b one cycle after acceptance, then c and the done pulse d one
//   cycle later. A holdoff window after reset refuses all requests; while
//   running, enable pauses and resumes acceptance. Refused requests, clean
//   completions and error-injected completions are counted with saturating
//   counters.
//   Ports:
//     clk    clock, all logic on the rising edge
//     rst_n  asynchronous active-low reset
//     bus    abc_responder_if slave modport (request, responses, statistics)
//   Parameters:
//     HOLDOFF_CYCLES  length of the post-reset refusal window (minimum 1)
//     CNT_W           statistics counter width, must match the bus CNT_W
// ---------------------------------------------------------------------------
module abc_responder
    import abc_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    abc_responder_if.slave  bus
);

    localparam int HC_W      = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam int HOLD_LAST = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [HC_W-1:0] hcnt_q;
    logic            ready_q;

    // ready is updated together with the state so it is a plain flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLDOFF;
            hcnt_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLDOFF: begin
                    // The count starts at 0 on the first edge after release,
                    // so the last holdoff cycle is the one where it reads
                    // HOLDOFF_CYCLES-1.
                    if (hcnt_q == HC_W'(HOLD_LAST)) begin
                        hcnt_q  <= '0;
                        state_q <= bus.enable ? ST_RUN : ST_PAUSE;
                        ready_q <= bus.enable;
                    end else begin
                        hcnt_q <= hcnt_q + HC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!bus.enable) begin
                        state_q <= ST_PAUSE;
                        ready_q <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (bus.enable) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_HOLDOFF;
                    hcnt_q  <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------
    // enable must be high in the same cycle as RUN; a request arriving on the
    // cycle enable drops is refused even though the state is still RUN.
    logic accept;
    logic refuse;

    assign accept = bus.a & bus.enable & (state_q == ST_RUN);
    assign refuse = bus.a & ~accept;

    // ------------------------------------------------------------------
    // Two-stage response pipeline
    //   stage 1 valid drives b, stage 2 valid drives d; each stage carries
    //   its own error flag so back-to-back transactions stay independent.
    // ------------------------------------------------------------------
    logic s1_v_q;
    logic s1_e_q;
    logic s2_v_q;
    logic s2_e_q;
    logic c_q;

    // The pipeline advances regardless of FSM state, so anything already
    // accepted completes even after a move to PAUSE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s1_e_q <= 1'b0;
            s2_v_q <= 1'b0;
            s2_e_q <= 1'b0;
            c_q    <= 1'b0;
        end else begin
            s1_v_q <= accept;
            s1_e_q <= accept & bus.inject_err;
            s2_v_q <= s1_v_q;
            s2_e_q <= s1_e_q;
            c_q    <= s1_v_q & ~s1_e_q;
        end
    end

    assign bus.b     = s1_v_q;
    assign bus.c     = c_q;
    assign bus.d     = s2_v_q;
    assign bus.busy  = s1_v_q | s2_v_q;
    assign bus.ready = ready_q;

    // ------------------------------------------------------------------
    // Statistics
    //   Completions are counted on the d cycle; reset clears the pipeline
    //   before any in-flight transaction can reach d, so it is never counted.
    // ------------------------------------------------------------------
    logic txn_inc;
    logic err_inc;

    assign txn_inc = s2_v_q & ~s2_e_q;
    assign err_inc = s2_v_q &  s2_e_q;

    sat_counter #(.W(CNT_W)) u_txn_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (txn_inc),
        .q     (bus.txn_count)
    );

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .q     (bus.err_count)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (refuse),
        .q     (bus.drop_count)
    );

endmodule : abc_responder

// File: tb/tb_abc_responder.sv
// ---------------------------------------------------------------------------
// tb_abc_responder
//   Directed bench for abc_responder. A default instance (CNT_W=16) covers
//   holdoff, pipelining, error injection, pause and reset; a CNT_W=4 instance
//   covers counter saturation. Inputs change 1 time unit after a rising edge
//   and outputs are sampled at that same point, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_abc_responder;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    abc_responder_if #(.CNT_W(16)) bus  ();
    abc_responder_if #(.CNT_W(4))  bus2 ();

    abc_responder #(.HOLDOFF_CYCLES(20), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    abc_responder #(.HOLDOFF_CYCLES(20), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // ------------------------------------------------------------------
    // Stimulus utilities
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a           = 1'b0;
        bus.enable      = 1'b0;
        bus.inject_err  = 1'b0;
        bus2.a          = 1'b0;
        bus2.enable     = 1'b0;
        bus2.inject_err = 1'b0;
    endtask

    // Leaves the bench in cycle 0: the next edge is the first after release.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Leaves the default instance in RUN, at cycle 20 after release.
    task automatic go_run();
        do_reset();
        bus.enable = 1'b1;
        repeat (20) step();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus.b, bus.c, bus.d, bus.busy, bus.ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got b,c,d,busy,ready=%b exp=00000",
                     {bus.b, bus.c, bus.d, bus.busy, bus.ready});
        end
        checks++;
        if ({bus.txn_count, bus.err_count, bus.drop_count} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters got txn=%0d err=%0d drop=%0d exp=0,0,0",
                     bus.txn_count, bus.err_count, bus.drop_count);
        end
        do_reset();
        bus.enable = 1'b1;
        repeat (5) step();
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_holdoff_ready got=%b exp=0", bus.ready);
        end
    endtask

    task automatic test_holdoff_drop();
        int first_ready = -1;
        int first_b     = -1;
        int first_c     = -1;
        do_reset();
        bus.enable = 1'b1;
        bus.a      = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (bus.ready && first_ready < 0) first_ready = k;
            if (bus.b && first_b < 0)         first_b = k;
            if (bus.c && first_c < 0)         first_c = k;
            if (k == 21) begin
                checks++;
                if (bus.drop_count !== 16'd20) begin
                    errors++;
                    $display("FAIL holdoff_drop_count got=%0d exp=20", bus.drop_count);
                end
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL holdoff_busy got=%b exp=1", bus.busy);
                end
            end
            step();
        end
        bus.a = 1'b0;
        checks++;
        if (first_ready != 20) begin
            errors++;
            $display("FAIL holdoff_ready_cycle got=%0d exp=20", first_ready);
        end
        checks++;
        if (first_b != 21) begin
            errors++;
            $display("FAIL holdoff_first_b got=%0d exp=21", first_b);
        end
        checks++;
        if (first_c != 22) begin
            errors++;
            $display("FAIL holdoff_first_c got=%0d exp=22", first_c);
        end
        // Cycle 24: drops frozen at 20, accepts at 20 and 21 already counted.
        checks++;
        if (bus.drop_count !== 16'd20 || bus.txn_count !== 16'd2) begin
            errors++;
            $display("FAIL holdoff_run_counters got drop=%0d txn=%0d exp drop=20 txn=2",
                     bus.drop_count, bus.txn_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] a_pat = 6'b000111;
        logic [5:0] exp_b = 6'b001110;
        logic [5:0] exp_c = 6'b011100;
        logic [5:0] exp_d = 6'b011100;
        go_run();
        for (int k = 0; k < 6; k++) begin
            bus.a = a_pat[k];
            checks++;
            if ({bus.b, bus.c, bus.d} !== {exp_b[k], exp_c[k], exp_d[k]}) begin
                errors++;
                $display("FAIL b2b_bcd off=%0d got=%b%b%b exp=%b%b%b", k,
                         bus.b, bus.c, bus.d, exp_b[k], exp_c[k], exp_d[k]);
            end
            if (k == 5) begin
                checks++;
                if (bus.txn_count !== 16'd3 || bus.err_count !== 16'd0 ||
                    bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_counters got txn=%0d err=%0d busy=%b exp txn=3 err=0 busy=0",
                             bus.txn_count, bus.err_count, bus.busy);
                end
            end
            step();
        end
    endtask

    task automatic test_inject_err();
        logic [5:0] exp_b = 6'b000010;
        logic [5:0] exp_c = 6'b000000;
        logic [5:0] exp_d = 6'b000100;
        go_run();
        for (int k = 0; k < 6; k++) begin
            bus.a          = (k == 0);
            bus.inject_err = (k == 0);
            checks++;
            if ({bus.b, bus.c, bus.d} !== {exp_b[k], exp_c[k], exp_d[k]}) begin
                errors++;
                $display("FAIL err_bcd off=%0d got=%b%b%b exp=%b%b%b", k,
                         bus.b, bus.c, bus.d, exp_b[k], exp_c[k], exp_d[k]);
            end
            step();
        end
        checks++;
        if (bus.err_count !== 16'd1 || bus.txn_count !== 16'd0) begin
            errors++;
            $display("FAIL err_counters got err=%0d txn=%0d exp err=1 txn=0",
                     bus.err_count, bus.txn_count);
        end
    endtask

    task automatic test_mixed_err();
        logic [5:0] a_pat = 6'b000111;
        logic [5:0] e_pat = 6'b000010;
        logic [5:0] exp_b = 6'b001110;
        logic [5:0] exp_c = 6'b010100;
        logic [5:0] exp_d = 6'b011100;
        go_run();
        for (int k = 0; k < 6; k++) begin
            bus.a          = a_pat[k];
            bus.inject_err = e_pat[k];
            checks++;
            if ({bus.b, bus.c, bus.d} !== {exp_b[k], exp_c[k], exp_d[k]}) begin
                errors++;
                $display("FAIL mixed_bcd off=%0d got=%b%b%b exp=%b%b%b", k,
                         bus.b, bus.c, bus.d, exp_b[k], exp_c[k], exp_d[k]);
            end
            step();
        end
        checks++;
        if (bus.txn_count !== 16'd2 || bus.err_count !== 16'd1) begin
            errors++;
            $display("FAIL mixed_counters got txn=%0d err=%0d exp txn=2 err=1",
                     bus.txn_count, bus.err_count);
        end
    endtask

    task automatic test_pause();
        // Accept at 0; refused at 1 (enable low while still RUN) and at 3
        // (enable high but still PAUSE); back in RUN from 4.
        logic [5:0] a_pat     = 6'b001011;
        logic [5:0] en_pat    = 6'b111001;
        logic [5:0] exp_b     = 6'b000010;
        logic [5:0] exp_c     = 6'b000100;
        logic [5:0] exp_d     = 6'b000100;
        logic [5:0] exp_ready = 6'b110011;
        go_run();
        for (int k = 0; k < 6; k++) begin
            bus.a      = a_pat[k];
            bus.enable = en_pat[k];
            checks++;
            if ({bus.b, bus.c, bus.d, bus.ready} !==
                {exp_b[k], exp_c[k], exp_d[k], exp_ready[k]}) begin
                errors++;
                $display("FAIL pause_bcd_ready off=%0d got=%b%b%b%b exp=%b%b%b%b", k,
                         bus.b, bus.c, bus.d, bus.ready,
                         exp_b[k], exp_c[k], exp_d[k], exp_ready[k]);
            end
            if (k == 5) begin
                checks++;
                if (bus.drop_count !== 16'd2 || bus.txn_count !== 16'd1) begin
                    errors++;
                    $display("FAIL pause_counters got drop=%0d txn=%0d exp drop=2 txn=1",
                             bus.drop_count, bus.txn_count);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_midflight();
        go_run();
        bus.a = 1'b1;
        repeat (3) step();
        bus.a = 1'b0;
        checks++;
        if (bus.b !== 1'b1 || bus.c !== 1'b1 || bus.txn_count !== 16'd1) begin
            errors++;
            $display("FAIL midflight_pre got b=%b c=%b txn=%0d exp b=1 c=1 txn=1",
                     bus.b, bus.c, bus.txn_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.b, bus.c, bus.d, bus.busy, bus.ready} !== 5'b0) begin
            errors++;
            $display("FAIL midflight_async_outputs got b,c,d,busy,ready=%b exp=00000",
                     {bus.b, bus.c, bus.d, bus.busy, bus.ready});
        end
        checks++;
        if ({bus.txn_count, bus.err_count, bus.drop_count} !== 48'd0) begin
            errors++;
            $display("FAIL midflight_async_counters got txn=%0d err=%0d drop=%0d exp=0,0,0",
                     bus.txn_count, bus.err_count, bus.drop_count);
        end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bus.d !== 1'b0 || bus.txn_count !== 16'd0) begin
                errors++;
                $display("FAIL midflight_in_reset edge=%0d got d=%b txn=%0d exp d=0 txn=0",
                         k, bus.d, bus.txn_count);
            end
        end
        rst_n = 1'b1;
        repeat (3) step();
        checks++;
        if (bus.txn_count !== 16'd0 || bus.err_count !== 16'd0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midflight_after got txn=%0d err=%0d busy=%b exp txn=0 err=0 busy=0",
                     bus.txn_count, bus.err_count, bus.busy);
        end
    endtask

    task automatic test_saturation();
        // a held high from cycle 0 to 36: 20 refusals, then 17 accepts.
        do_reset();
        bus2.enable = 1'b1;
        for (int k = 0; k < 37; k++) begin
            bus2.a = 1'b1;
            if (k == 35) begin
                checks++;
                if (bus2.txn_count !== 4'd13) begin
                    errors++;
                    $display("FAIL sat_txn_mid got=%0d exp=13", bus2.txn_count);
                end
            end
            step();
        end
        bus2.a = 1'b0;
        checks++;
        if (bus2.drop_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_drop got=%0d exp=15", bus2.drop_count);
        end
        repeat (3) step();
        checks++;
        if (bus2.txn_count !== 4'd15 || bus2.err_count !== 4'd0 ||
            bus2.drop_count !== 4'd15) begin
            errors++;
            $display("FAIL sat_final got txn=%0d err=%0d drop=%0d exp txn=15 err=0 drop=15",
                     bus2.txn_count, bus2.err_count, bus2.drop_count);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_holdoff_drop();
        test_back_to_back();
        test_inject_err();
        test_mixed_err();
        test_pause();
        test_reset_midflight();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the test sequence completed");
        $fatal(1, "watchdog");
    end

endmodule : tb_abc_responder
